// File: rtl/shot_sequencer_if.sv
// +------------------------------------------------------------------+
// | shot_sequencer_if : scoring request / result link to the checker |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

interface shot_sequencer_if;
  logic [3:0] shot_x;
  logic [3:0] shot_y;
  logic       shot_big;
  logic       score_valid;
  logic       score_ready;
  logic       result_valid;
  logic [3:0] result_hits;

  modport master (
    output shot_x, shot_y, shot_big, score_valid,
    input  score_ready, result_valid, result_hits
  );

  modport slave (
    input  shot_x, shot_y, shot_big, score_valid,
    output score_ready, result_valid, result_hits
  );
endinterface

`default_nettype wire

// File: rtl/shot_sequencer.sv
// +------------------------------------------------------------------+
// | shot_sequencer : fire-button conditioning, shot validation, big- |
// | bomb inventory and hit accumulation. Option macro: SHOT_LIMIT_EN |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module shot_sequencer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int MAX_BIG         = 2,
  parameter int TOTAL_SQUARES   = 19,
  parameter int MAX_SHOTS       = 40
) (
  input  wire logic        clock,
  input  wire logic        reset_L,
  input  wire logic        fire_key_L,
  input  wire logic [3:0]  x_in,
  input  wire logic [3:0]  y_in,
  input  wire logic        big_in,
  shot_sequencer_if.master sif,
  output logic [1:0]       big_left,
  output logic             wrong,
  output logic [4:0]       num_hits,
  output logic [3:0]       hits_ones,
  output logic [3:0]       hits_tens,
`ifdef SHOT_LIMIT_EN
  output logic [5:0]       shots_left,
`endif
  output logic             game_over
);

  localparam int         CW          = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [5:0] TOTAL_W     = 6'(TOTAL_SQUARES);
  localparam logic [1:0] MAX_BIG_W   = 2'(MAX_BIG);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, OVER = 2'd3} state_t;

  logic [1:0]    sync_q;
  logic          db_q;
  logic [CW-1:0] db_cnt_q;
  logic          press_q;

  state_t        state_q;
  logic [3:0]    shot_x_q, shot_y_q;
  logic          shot_big_q, score_valid_q, wrong_q, game_over_q;
  logic [1:0]    big_left_q;
  logic [4:0]    num_hits_q;
  logic [3:0]    hits_ones_q, hits_tens_q;

  logic [5:0]    hits_sum;
  logic [4:0]    num_hits_d;
  logic [7:0]    bcd_d;
  logic          shot_ok;

  // A level change is taken only after the synchronized key disagrees with
  // the accepted level for DEBOUNCE_CYCLES samples in a row.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      sync_q   <= 2'b11;
      db_q     <= 1'b1;
      db_cnt_q <= '0;
      press_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], fire_key_L};
      press_q <= 1'b0;
      if (sync_q[1] == db_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        db_q     <= sync_q[1];
        db_cnt_q <= '0;
        press_q  <= ~sync_q[1];
      end else begin
        db_cnt_q <= db_cnt_q + 1'b1;
      end
    end
  end

  function automatic logic [7:0] to_bcd(input logic [4:0] v);
    logic [3:0] t, o;
    if (v >= 5'd30)      begin t = 4'd3; o = 4'(v - 5'd30); end
    else if (v >= 5'd20) begin t = 4'd2; o = 4'(v - 5'd20); end
    else if (v >= 5'd10) begin t = 4'd1; o = 4'(v - 5'd10); end
    else                 begin t = 4'd0; o = v[3:0];        end
    return {t, o};
  endfunction

  assign hits_sum   = {1'b0, num_hits_q} + {2'b00, sif.result_hits};
  assign num_hits_d = (hits_sum > TOTAL_W) ? TOTAL_W[4:0] : hits_sum[4:0];
  assign bcd_d      = to_bcd(num_hits_d);
  assign shot_ok    = (x_in >= 4'd1) && (x_in <= 4'd10) &&
                      (y_in >= 4'd1) && (y_in <= 4'd10) &&
                      !(big_in && (big_left_q == 2'd0));

`ifdef SHOT_LIMIT_EN
  localparam logic [5:0] MAX_SHOTS_W = 6'(MAX_SHOTS);
  logic [5:0] shots_taken_q;

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L)
      shots_taken_q <= '0;
    else if (state_q == REQ && sif.score_ready)
      shots_taken_q <= shots_taken_q + 6'd1;
  end

  assign shots_left = MAX_SHOTS_W - shots_taken_q;
`endif

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state_q       <= IDLE;
      shot_x_q      <= '0;
      shot_y_q      <= '0;
      shot_big_q    <= 1'b0;
      score_valid_q <= 1'b0;
      wrong_q       <= 1'b0;
      big_left_q    <= MAX_BIG_W;
      num_hits_q    <= '0;
      hits_ones_q   <= '0;
      hits_tens_q   <= '0;
      game_over_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (press_q) begin
            shot_x_q   <= x_in;
            shot_y_q   <= y_in;
            shot_big_q <= big_in;
            wrong_q    <= ~shot_ok;
            if (shot_ok) begin
              score_valid_q <= 1'b1;
              state_q       <= REQ;
            end
          end
        end
        REQ: begin
          if (sif.score_ready) begin
            score_valid_q <= 1'b0;
            state_q       <= WAIT;
            if (shot_big_q && (big_left_q != 2'd0))
              big_left_q <= big_left_q - 2'd1;
          end
        end
        WAIT: begin
          if (sif.result_valid) begin
            num_hits_q  <= num_hits_d;
            hits_tens_q <= bcd_d[7:4];
            hits_ones_q <= bcd_d[3:0];
            if ({1'b0, num_hits_d} == TOTAL_W) begin
              state_q     <= OVER;
              game_over_q <= 1'b1;
            end
`ifdef SHOT_LIMIT_EN
            else if (shots_taken_q == MAX_SHOTS_W) begin
              state_q     <= OVER;
              game_over_q <= 1'b1;
            end
`endif
            else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          game_over_q <= 1'b1;
        end
      endcase
    end
  end

  assign sif.shot_x      = shot_x_q;
  assign sif.shot_y      = shot_y_q;
  assign sif.shot_big    = shot_big_q;
  assign sif.score_valid = score_valid_q;
  assign big_left        = big_left_q;
  assign wrong           = wrong_q;
  assign num_hits        = num_hits_q;
  assign hits_ones       = hits_ones_q;
  assign hits_tens       = hits_tens_q;
  assign game_over       = game_over_q;

endmodule

`default_nettype wire

// File: doc/shot_sequencer.md
Name: shot_sequencer

Overview:
- Front-end controller for the Battleship scoring path. It sits upstream of the combinational hit/miss/near-miss checker and the LED/HEX display logic.
- Conditions the raw fire button, latches and validates the shot coordinates, and manages the big-bomb inventory.
- Issues one scoring request per accepted shot over a valid/ready handshake, then accumulates the returned hit count into a running total for the HEX display.
- Detects game end when every ship square has been hit.

Parameters:
- DEBOUNCE_CYCLES, 16: number of consecutive stable synchronized samples required before a button level change is accepted.
- MAX_BIG, 2: big bombs available after reset. Legal range 0..2.
- TOTAL_SQUARES, 19: ship squares on the board (2+2+3+3+4+5). Reaching this count ends the game.
- MAX_SHOTS, 40: shot limit. Used only when SHOT_LIMIT_EN is defined.

Ports:
- clock  in  1  system clock. All state is on the rising edge.
- reset_L  in  1  asynchronous, active-low reset.
- fire_key_L  in  1  raw KEY[0]. Active low, asynchronous to clock, bouncy.
- x_in  in  4  column from SW[7:4].
- y_in  in  4  row from SW[3:0].
- big_in  in  1  big-bomb request from SW[17].
- shot_x  out  4  latched column, stable while score_valid=1.
- shot_y  out  4  latched row, stable while score_valid=1.
- shot_big  out  1  latched big flag.
- score_valid  out  1  scoring request to the downstream checker.
- score_ready  in  1  checker accepts the request.
- result_valid  in  1  one-cycle strobe carrying the checker's result.
- result_hits  in  4  number of newly hit squares, 0..9.
- big_left  out  2  big bombs remaining.
- wrong  out  1  last press was rejected. Drives HEX6/HEX7.
- num_hits  out  5  total squares hit, 0..TOTAL_SQUARES.
- hits_ones  out  4  BCD ones digit of num_hits.
- hits_tens  out  4  BCD tens digit of num_hits.
- game_over  out  1  game finished.

Behaviour:
- Reset values:
  - state=IDLE.
  - shot_x=0, shot_y=0, shot_big=0, score_valid=0, wrong=0.
  - big_left=MAX_BIG, num_hits=0, hits_ones=0, hits_tens=0, game_over=0.
  - Synchronizer and debounce registers are reset to the released level (1).
- Button conditioning:
  - 2-flop synchronizer on fire_key_L.
  - Debounce counter accepts a level change only after DEBOUNCE_CYCLES consecutive equal synchronized samples.
  - press = a one-cycle pulse on the debounced 1->0 transition.
  - Holding the key produces exactly one press.
- FSM states: IDLE, REQ, WAIT, OVER.
- IDLE, on press:
  - Latch x_in, y_in and big_in into shot_x, shot_y and shot_big, all in the same cycle.
  - The shot is invalid if x or y is outside 1..10, or if big_in=1 while big_left=0.
  - Invalid shot: wrong<=1, stay in IDLE. big_left and num_hits are unchanged.
  - Valid shot: wrong<=0, go to REQ.
- REQ:
  - score_valid=1, and shot_x, shot_y and shot_big hold steady.
  - On the cycle where score_valid&score_ready=1: score_valid<=0, go to WAIT.
  - On that same handshake, if shot_big=1 then big_left decrements by 1. It never decrements below 0.
- WAIT, on result_valid:
  - num_hits <= min(num_hits + result_hits, TOTAL_SQUARES). Use a 6-bit intermediate sum, then saturate.
  - If the new num_hits equals TOTAL_SQUARES: go to OVER. Otherwise go to IDLE.
  - result_valid outside WAIT is ignored.
  - A result_valid in the same cycle as the REQ handshake is ignored. The result must arrive at least 1 cycle after the handshake.
- OVER: game_over=1. All presses are ignored. Only reset leaves this state.
- Presses in REQ, WAIT or OVER are dropped, not queued.
- hits_ones and hits_tens are registered and update on the same edge as num_hits.
  - Example: num_hits=19 gives tens=1, ones=9.
- Reset asserted mid-handshake: score_valid drops immediately (asynchronously). No partial update of big_left or num_hits.
- Latency: press pulse to score_valid=1 is 1 cycle. result_valid to num_hits update is 1 cycle.

Optional Feature:
- Macro: SHOT_LIMIT_EN.
- When defined:
  - A 6-bit shots_taken counter increments on each REQ handshake.
  - The extra output port shots_left[5:0] = MAX_SHOTS - shots_taken.
  - When a WAIT result leaves shots_taken == MAX_SHOTS, the FSM goes to OVER even if num_hits < TOTAL_SQUARES.
- When undefined: no counter and no shots_left port. The only exit to OVER is the hit total.

Test Plan:
- Reset, then x_in=3, y_in=2, big_in=0, press key with 5 cycles of bounce -> exactly one request: score_valid=1 with shot_x=3, shot_y=2. After score_ready, result_hits=1 -> num_hits=1, hits_ones=1, wrong=0.
- Press with x_in=0, y_in=5 -> wrong=1, score_valid stays 0, num_hits unchanged. Next valid press at (5,5) -> wrong=0.
- Three big shots, each acknowledged with result_hits=0 -> big_left goes 2, 1, 0. The third shot is rejected with wrong=1 and big_left stays 0.
- Hold score_ready=0 for 10 cycles while pressing again -> shot_x and shot_y stay stable, the second press is dropped, and only one request is issued.
- Accumulate results 9, 9, 3 -> num_hits saturates at 19, tens=1, ones=9, game_over=1. A further press is ignored.
- Assert reset_L=0 while in REQ -> score_valid=0 immediately. After release, big_left=2, num_hits=0, state IDLE.
